// File: rtl/spi_slave_port.sv
// SPI slave endpoint: 16-bit (N-bit) words, CPOL=0 / CPHA=1, MSB first.
// SCK/SSEL/MOSI are oversampled on clk_i; the master must run SCK at
// most clk_i/8 so every half-period spans several system clocks.
// A single-entry TX buffer with req/ack handshake feeds the shifter,
// and each completed RX word is presented on do_o with a 1-cycle strobe.
module spi_slave_port #(
   parameter int             N       = 16,
   parameter logic [N-1:0]   TX_IDLE = '0
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         spi_sck_i,
   input  logic         spi_ssel_i,
   input  logic         spi_mosi_i,
   output logic         spi_miso_o,
   output logic         spi_miso_oe_o,
   input  logic [N-1:0] di_i,
   input  logic         wren_i,
   output logic         di_req_o,
   output logic         wr_ack_o,
   output logic [N-1:0] do_o,
   output logic         do_valid_o,
   output logic         tx_underrun_o,
   output logic         frame_err_o
);

   localparam int             CW   = (N > 2) ? $clog2(N) : 1;
   localparam logic [CW-1:0]  LAST = CW'(N - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t          state, state_nxt;

   // [0] = sync stage 1, [1] = sync stage 2, [2] = history (edge reference)
   logic [2:0]      sck_p, ssel_p;
   // MOSI is only ever sampled, never edge-detected, so it needs no history flop
   logic [1:0]      mosi_p;

   logic            sck_rise, sck_fall, ssel_rise, ssel_fall, mosi_s;

   logic [CW-1:0]   bit_cnt;
   logic [N-1:0]    tx_shift, rx_shift, tx_buf, do_r;
   logic            tx_full, wr_ack, do_valid, tx_underrun, frame_err;
   logic            miso, miso_oe;

   // FSM control strobes
   logic            open_frame, close_frame, launch, capture, word_end, ld;
   logic            wr_ok;

   // two-flop synchronisers plus edge-history flop; SSEL idles high
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sck_p  <= 3'b000;
         ssel_p <= 3'b111;
         mosi_p <= 2'b00;
      end else begin
         sck_p  <= {sck_p[1:0], spi_sck_i};
         ssel_p <= {ssel_p[1:0], spi_ssel_i};
         mosi_p <= {mosi_p[0], spi_mosi_i};
      end
   end

   assign sck_rise  =  sck_p[1]  & ~sck_p[2];
   assign sck_fall  = ~sck_p[1]  &  sck_p[2];
   assign ssel_rise =  ssel_p[1] & ~ssel_p[2];
   assign ssel_fall = ~ssel_p[1] &  ssel_p[2];
   assign mosi_s    =  mosi_p[1];

   // state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   // next state and per-cycle control; SSEL rising beats any SCK edge
   always_comb begin
      state_nxt   = state;
      open_frame  = 1'b0;
      close_frame = 1'b0;
      launch      = 1'b0;
      capture     = 1'b0;
      word_end    = 1'b0;
      ld          = 1'b0;
      case (state)
         IDLE: begin
            if (ssel_fall) begin
               state_nxt  = SHIFT;
               open_frame = 1'b1;
               ld         = 1'b1;
            end
         end
         SHIFT: begin
            if (ssel_rise) begin
               state_nxt   = IDLE;
               close_frame = 1'b1;
            end else begin
               launch   = sck_rise;
               capture  = sck_fall;
               word_end = sck_fall && (bit_cnt == LAST);
               ld       = word_end;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // a write is taken only into an empty buffer; the full flag is sampled
   // before this cycle's load, so a same-cycle load from empty underruns
   // while the write still fills the buffer for the next word
   assign wr_ok = wren_i & ~tx_full;

   // TX buffer and handshake strobes
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tx_buf      <= '0;
         tx_full     <= 1'b0;
         wr_ack      <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         wr_ack      <= wr_ok;
         tx_underrun <= ld & ~tx_full;
         if (wr_ok) begin
            tx_buf  <= di_i;
            tx_full <= 1'b1;
         end else if (ld) begin
            tx_full <= 1'b0;
         end
      end
   end

   // shift datapath: launch on SCK rise, capture on SCK fall
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tx_shift  <= '0;
         rx_shift  <= '0;
         bit_cnt   <= '0;
         do_r      <= '0;
         do_valid  <= 1'b0;
         frame_err <= 1'b0;
         miso      <= 1'b0;
         miso_oe   <= 1'b0;
      end else begin
         do_valid  <= 1'b0;
         frame_err <= 1'b0;

         if (open_frame) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            miso_oe  <= 1'b1;
         end

         // partial words are dropped; only a non-zero count is an error
         if (close_frame) begin
            frame_err <= (bit_cnt != '0);
            bit_cnt   <= '0;
            rx_shift  <= '0;
            miso_oe   <= 1'b0;
            miso      <= 1'b0;
         end

         if (launch) begin
            miso     <= tx_shift[N-1];
            tx_shift <= {tx_shift[N-2:0], 1'b0};
         end

         if (capture) begin
            rx_shift <= {rx_shift[N-2:0], mosi_s};
            if (word_end) begin
               do_r     <= {rx_shift[N-2:0], mosi_s};
               do_valid <= 1'b1;
               bit_cnt  <= '0;
            end else begin
               bit_cnt  <= bit_cnt + 1'b1;
            end
         end

         // frame start or word boundary: next word from buffer, else idle pattern
         if (ld) tx_shift <= tx_full ? tx_buf : TX_IDLE;
      end
   end

   assign spi_miso_o    = miso;
   assign spi_miso_oe_o = miso_oe;
   assign di_req_o      = ~tx_full;
   assign wr_ack_o      = wr_ack;
   assign do_o          = do_r;
   assign do_valid_o    = do_valid;
   assign tx_underrun_o = tx_underrun;
   assign frame_err_o   = frame_err;

endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: behavioural CPHA=1 master at SCK = clk/10,
// scoreboard queues for RX words (checked on do_valid_o) and MISO words.
`timescale 1ns/1ps
module tb_spi_slave_port;

   logic        clk = 1'b0, rst = 1'b1;
   logic        sck = 1'b0, ssel = 1'b1, mosi = 1'b0;
   logic        miso, miso_oe;
   logic [15:0] di = '0;
   logic        wren = 1'b0;
   logic        di_req, wr_ack, do_valid, urun, ferr;
   logic [15:0] do_w;

   int n_cmp = 0, n_err = 0;
   int n_valid = 0, n_ack = 0, n_urun = 0, n_ferr = 0;
   logic [15:0] exp_rx[$];
   logic [15:0] exp_miso[$];

   always #5 clk = ~clk;

   spi_slave_port #(.N(16), .TX_IDLE(16'hFFFF)) dut (
      .clk_i(clk), .rst_i(rst),
      .spi_sck_i(sck), .spi_ssel_i(ssel), .spi_mosi_i(mosi),
      .spi_miso_o(miso), .spi_miso_oe_o(miso_oe),
      .di_i(di), .wren_i(wren), .di_req_o(di_req), .wr_ack_o(wr_ack),
      .do_o(do_w), .do_valid_o(do_valid),
      .tx_underrun_o(urun), .frame_err_o(ferr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // output monitor: pulse counters and RX scoreboard
   always @(negedge clk) begin
      if (do_valid) begin
         n_valid++;
         chk("rx_expected", 32'(exp_rx.size() != 0), 32'd1);
         if (exp_rx.size() != 0) chk("rx_word", 32'(do_w), 32'(exp_rx.pop_front()));
      end
      if (wr_ack) n_ack++;
      if (urun)   n_urun++;
      if (ferr)   n_ferr++;
   end

   task automatic wr(input logic [15:0] d);
      @(negedge clk); di = d; wren = 1'b1;
      @(negedge clk); wren = 1'b0;
      @(negedge clk);
   endtask

   task automatic sel();
      @(negedge clk); ssel = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic desel();
      repeat (5) @(negedge clk); ssel = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   // master shifts nb bits: drive MOSI on SCK rise, sample MISO before SCK fall
   task automatic xfer(input logic [15:0] tx, input int nb, output logic [15:0] rx);
      rx = '0;
      for (int i = 0; i < nb; i++) begin
         sck = 1'b1; mosi = tx[15-i];
         repeat (5) @(negedge clk);
         rx = {rx[14:0], miso};
         sck = 1'b0;
         repeat (5) @(negedge clk);
      end
   endtask

   task automatic word(input logic [15:0] tx);
      logic [15:0] rx;
      exp_rx.push_back(tx);
      xfer(tx, 16, rx);
      chk("miso_expected", 32'(exp_miso.size() != 0), 32'd1);
      if (exp_miso.size() != 0) chk("miso_word", 32'(rx), 32'(exp_miso.pop_front()));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: sim time exceeded");
      $fatal(1, "timeout");
   end

   initial begin
      int a0, u0, v0, f0;
      logic [15:0] junk;

      repeat (3) @(negedge clk);
      chk("reset_outs", {miso, miso_oe, di_req, wr_ack, do_w, do_valid, urun, ferr},
          {1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // 1: preloaded word out, 1234 in
      a0 = n_ack; wr(16'hA5C3);
      chk("t1_ack", a0 + 1, n_ack);
      chk("t1_req_full", di_req, 1'b0);
      exp_miso.push_back(16'hA5C3);
      u0 = n_urun; v0 = n_valid;
      sel();
      chk("t1_req_empty", di_req, 1'b1);
      chk("t1_oe", miso_oe, 1'b1);
      chk("t1_no_urun", n_urun - u0, 0);
      word(16'h1234);
      desel();
      chk("t1_nvalid", n_valid - v0, 1);
      chk("t1_do", do_w, 16'h1234);

      // 2: back-to-back words, buffer refilled after first load
      wr(16'h1357); exp_miso.push_back(16'h1357);
      v0 = n_valid; f0 = n_ferr;
      sel();
      wr(16'h0F0F); exp_miso.push_back(16'h0F0F);
      word(16'hBEEF);
      word(16'hCAFE);
      desel();
      chk("t2_nvalid", n_valid - v0, 2);
      chk("t2_no_ferr", n_ferr - f0, 0);
      chk("t2_do", do_w, 16'hCAFE);

      // 3: empty buffer -> TX_IDLE with underrun at frame start
      u0 = n_urun;
      sel();
      chk("t3_urun", n_urun - u0, 1);
      exp_miso.push_back(16'hFFFF);
      word(16'h0001);
      desel();
      chk("t3_do", do_w, 16'h0001);

      // 4: abort after 7 bits, then a full frame
      f0 = n_ferr; v0 = n_valid;
      sel();
      xfer(16'h9999, 7, junk);
      desel();
      chk("t4_ferr", n_ferr - f0, 1);
      chk("t4_nvalid", n_valid - v0, 0);
      chk("t4_do_kept", do_w, 16'h0001);
      chk("t4_oe", miso_oe, 1'b0);
      chk("t4_miso", miso, 1'b0);
      sel();
      exp_miso.push_back(16'hFFFF);
      word(16'h5555);
      desel();
      chk("t4_do_next", do_w, 16'h5555);

      // 5: second write while full is ignored
      a0 = n_ack;
      wr(16'h1111);
      wr(16'h2222);
      chk("t5_ack", n_ack - a0, 1);
      exp_miso.push_back(16'h1111);
      sel();
      word(16'h2468);
      desel();
      chk("t5_do", do_w, 16'h2468);

      // 6: reset at bit 9, then a clean frame
      v0 = n_valid; f0 = n_ferr;
      sel();
      xfer(16'hABCD, 9, junk);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      chk("t6_reset_outs", {miso, miso_oe, di_req, wr_ack, do_w, do_valid, urun, ferr},
          {1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});
      ssel = 1'b1; sck = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("t6_nvalid", n_valid - v0, 0);
      chk("t6_ferr", n_ferr - f0, 0);
      sel();
      exp_miso.push_back(16'hFFFF);
      word(16'h8001);
      desel();
      chk("t6_do", do_w, 16'h8001);

      chk("rx_left", exp_rx.size(), 0);
      chk("miso_left", exp_miso.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
